// File: rtl/pc_branch_unit.sv
// Program counter with conditional branch / absolute jump redirect and a one-cycle fetch flush.
// Optional saturating taken-redirect counter enabled by defining BRANCH_COUNT_EN.
module pc_branch_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       branch,
    input  logic       jump,
    input  logic [2:0] cond,
    input  logic [7:0] offset,
    input  logic [7:0] target,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic [7:0] pc,
    output logic       taken,
    output logic       flush
`ifdef BRANCH_COUNT_EN
    ,
    output logic [7:0] branch_count
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       flush_q, flush_d;
    logic       cond_true;
    logic       lt;

    assign lt = sf ^ of;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = zf;
            3'b001:  cond_true = ~zf;
            3'b010:  cond_true = lt;
            3'b011:  cond_true = ~lt;
            3'b100:  cond_true = ~zf & ~lt;
            3'b101:  cond_true = zf | lt;
            3'b110:  cond_true = of;
            default: cond_true = 1'b1;
        endcase
    end

    // A stall freezes everything; in FLUSH requests are ignored and fetch just advances.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken   = 1'b0;
        if (!stall) begin
            pc_d    = pc_q + 8'd1;
            state_d = ST_RUN;
            if (state_q == ST_RUN) begin
                taken = jump | (branch & cond_true);
                if (jump) begin
                    pc_d = target;
                end else if (taken) begin
                    // 8-bit add of the raw offset is the sign-extended add modulo 256.
                    pc_d = pc_q + 8'd1 + offset;
                end
                if (taken) begin
                    state_d = ST_FLUSH;
                end
            end
        end
        flush_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= 8'h00;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign pc    = pc_q;
    assign flush = flush_q;

`ifdef BRANCH_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (taken && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign branch_count = count_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed/random bench for pc_branch_unit: a behavioural model pushes expected pc/flush
// per edge into a queue, popped and compared after the edge.
module tb_pc_branch_unit;

    logic       clk;
    logic       reset, stall, branch, jump;
    logic [2:0] cond;
    logic [7:0] offset, target;
    logic       zf, sf, of;
    logic [7:0] pc;
    logic       taken, flush;
`ifdef BRANCH_COUNT_EN
    logic [7:0] branch_count;
`endif

    pc_branch_unit dut (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .branch (branch),
        .jump   (jump),
        .cond   (cond),
        .offset (offset),
        .target (target),
        .zf     (zf),
        .sf     (sf),
        .of     (of),
        .pc     (pc),
        .taken  (taken),
        .flush  (flush)
`ifdef BRANCH_COUNT_EN
        ,
        .branch_count (branch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] pc;
        logic       flush;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int tests = 0;
    int fails = 0;

    // Model state
    logic [7:0] m_pc;
    logic       m_in_flush;
    logic       m_flush;
    logic [7:0] m_cnt;

    function automatic logic cond_eval(input logic [2:0] c, input logic z, input logic s, input logic o);
        logic less;
        less = (s != o);
        case (c)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return less;
            3'd3: return !less;
            3'd4: return (!z) && (!less);
            3'd5: return z || less;
            3'd6: return o;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic br, input logic jp,
                        input logic [2:0] c, input logic [7:0] off, input logic [7:0] tgt,
                        input logic z, input logic s, input logic o);
        logic e_taken;
        exp_t e, got;
        int   npc;
        reset = r; stall = st; branch = br; jump = jp;
        cond = c; offset = off; target = tgt; zf = z; sf = s; of = o;
        #1;
        e_taken = 1'b0;
        if (r) begin
            m_pc = 8'h00; m_in_flush = 1'b0; m_flush = 1'b0; m_cnt = 8'h00;
        end else if (st) begin
            e_taken = 1'b0;
        end else if (m_in_flush) begin
            m_pc = m_pc + 8'd1; m_in_flush = 1'b0; m_flush = 1'b0;
        end else begin
            e_taken = jp || (br && cond_eval(c, z, s, o));
            if (jp) begin
                npc = int'(tgt);
            end else if (e_taken) begin
                npc = (int'(m_pc) + 1 + int'($signed(off))) & 255;
            end else begin
                npc = (int'(m_pc) + 1) % 256;
            end
            m_pc = 8'(npc);
            m_in_flush = e_taken;
            m_flush = e_taken;
            if (e_taken && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        if (!r) begin
            tests++;
            assert (taken === e_taken) else begin
                fails++;
                $error("FAIL taken: observed %b expected %b (pc=%h cond=%0d)", taken, e_taken, pc, c);
            end
        end
        e.pc = m_pc; e.flush = m_flush; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        $display("[TB] r=%b st=%b br=%b jp=%b cond=%0d off=%h tgt=%h -> pc=%h flush=%b",
                 r, st, br, jp, c, off, tgt, pc, flush);
        chk8("pc", pc, got.pc);
        chk8("flush", {7'd0, flush}, {7'd0, got.flush});
`ifdef BRANCH_COUNT_EN
        chk8("branch_count", branch_count, got.cnt);
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
    endtask

    task automatic jump_to(input logic [7:0] t);
        step(0, 0, 0, 1, 3'd0, 8'h00, t, 0, 0, 0);
    endtask

    initial begin
        m_pc = 8'h00; m_in_flush = 1'b0; m_flush = 1'b0; m_cnt = 8'h00;
        reset = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0;
        cond = 3'd0; offset = 8'h00; target = 8'h00; zf = 1'b0; sf = 1'b0; of = 1'b0;

        // Reset wins over stall/branch/jump
        step(1, 1, 1, 1, 3'd7, 8'h55, 8'hAA, 1, 1, 1);
        chk8("reset_pc", pc, 8'h00);
        chk8("reset_flush", {7'd0, flush}, 8'h00);

        // Sequential run
        idle(); idle(); idle();
        chk8("seq_pc3", pc, 8'h03);

        // BEQ taken backward from 0x10
        jump_to(8'h0F);
        idle();
        chk8("pc_at_10", pc, 8'h10);
        step(0, 0, 1, 0, 3'd0, 8'hFC, 8'h00, 1, 0, 0);
        chk8("beq_pc", pc, 8'h0D);
        chk8("beq_flush", {7'd0, flush}, 8'h01);
        step(0, 0, 1, 0, 3'd0, 8'hFC, 8'h00, 1, 0, 0);
        chk8("beq_after_pc", pc, 8'h0E);
        chk8("beq_after_flush", {7'd0, flush}, 8'h00);

        // BLT not taken at 0x20
        jump_to(8'h1F);
        idle();
        step(0, 0, 1, 0, 3'd2, 8'h10, 8'h00, 0, 1, 1);
        chk8("blt_pc", pc, 8'h21);
        chk8("blt_flush", {7'd0, flush}, 8'h00);

        // Jump priority, then jump ignored in FLUSH
        step(0, 0, 1, 1, 3'd7, 8'h05, 8'h80, 0, 0, 0);
        chk8("jprio_pc", pc, 8'h80);
        jump_to(8'h40);
        chk8("jflush_pc", pc, 8'h81);

        // Random condition coverage, including stalls and FLUSH-cycle requests
        for (int i = 0; i < 48; i++) begin
            logic [2:0] rc;
            logic [7:0] ro;
            rc = 3'(i % 8);
            ro = 8'($urandom);
            step(0, (i % 7) == 3, 1'($urandom_range(0, 1)), (i % 11) == 5, rc, ro, 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Stall and wrap at 0xFF
        jump_to(8'hFE);
        idle();
        chk8("pc_ff", pc, 8'hFF);
        step(0, 1, 1, 1, 3'd7, 8'h00, 8'h33, 0, 0, 0);
        step(0, 1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
        chk8("stall_hold_pc", pc, 8'hFF);
        idle();
        chk8("wrap_pc", pc, 8'h00);

        // Stall holds an active flush
        jump_to(8'h50);
        step(0, 1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
        chk8("stall_flush_hold", {7'd0, flush}, 8'h01);
        idle();
        chk8("stall_flush_pc", pc, 8'h51);

        // Reset during FLUSH
        jump_to(8'h60);
        step(1, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
        chk8("rst_flush_pc", pc, 8'h00);
        chk8("rst_flush_flush", {7'd0, flush}, 8'h00);
        idle();
        chk8("rst_flush_next", pc, 8'h01);

`ifdef BRANCH_COUNT_EN
        // 300 taken jumps need 600 edges since every other edge is a FLUSH cycle
        for (int i = 0; i < 600; i++) jump_to(8'(i));
        chk8("count_sat", branch_count, 8'hFF);
        step(1, 0, 0, 0, 3'd0, 8'h00, 8'h00, 0, 0, 0);
        chk8("count_reset", branch_count, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
